// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, centre sampling, framing check.
// Ports: clk, rst_n, rx_pin -> byte_received[7:0], rx_done, rx_busy, frame_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] byte_received,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [7:0]    shreg;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      shreg         <= 8'h00;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      byte_received <= 8'h00;
      rx_done       <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sync1   <= rx_pin;
      rx_s    <= sync1;
      rx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            // a start bit gone high by its centre is a glitch
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_received <= shreg;
              rx_done       <= 1'b1;
              frame_err     <= 1'b0;
              state         <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // hold off until the line idles so a break is not a start bit
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
